dram_strobe_responder: RTL and testbench
========================================

Name: dram_strobe_responder

Overview:
- Memory-side responder for the DRAM strobes produced by the machine clock source: t_RASn, t_CASn and t_RAM_WRn.
- Samples the strobes on the system clock and latches row then column from the multiplexed address bus.
- Performs the read or write against an internal array and flags strobe-protocol violations.
- Serves as the RAM model behind the emulator's memory port and as an in-line protocol checker for the clock generator.

Parameters:
- ROW_W, 6, row address width; also the width of the multiplexed address bus.
- COL_W, 6, column address width; must be less than or equal to ROW_W; the column is taken from ma[COL_W-1:0].
- DATA_W, 8, data word width; the array depth is 2^(ROW_W+COL_W).

Ports:
- xtal_in  in  1  system clock; all logic runs on the rising edge.
- init_n  in  1  synchronous reset, active low.
- t_RASn  in  1  row strobe, active low.
- t_CASn  in  1  column strobe, active low.
- t_RAM_WRn  in  1  write strobe, active low.
- ma  in  ROW_W  multiplexed row/column address.
- din  in  DATA_W  write data.
- dout  out  DATA_W  read data.
- dout_valid  out  1  dout holds data for the current column access.
- row_open  out  1  a row is latched (RAS active).
- err_cas_no_ras  out  1  sticky: CAS fell while no row was open.
- err_wr_no_cas  out  1  sticky: WR fell while CAS was inactive.
- err_precharge  out  1  sticky: RAS fell during the precharge cycle.

Behaviour:
- Edge detection:
  - Each strobe is registered every cycle into ras_q, cas_q and wr_q.
  - A fall is current==0 with the registered value==1; a rise is current==1 with the registered value==0.
  - All actions occur at the clock edge where the fall or rise is detected.
- Reset (init_n==0 at a rising edge):
  - state=IDLE; dout=0; dout_valid=0; row_open=0; all err_* cleared to 0.
  - ras_q, cas_q and wr_q are set to 1, so a strobe still low when reset releases is seen as a fall.
  - Array contents are preserved.
  - Reset mid-access aborts the access with no write.
- States:
  - IDLE:
    - RAS fall: row<=ma, row_open<=1, go to ROW.
    - CAS fall: set err_cas_no_ras, no access.
  - ROW:
    - CAS fall: col<=ma[COL_W-1:0], go to COL.
    - If t_RAM_WRn==0 at that edge (early write): mem[{row,ma[COL_W-1:0]}]<=din and mark the access as written.
    - Otherwise: dout<=mem[{row,ma[COL_W-1:0]}] and dout_valid<=1. Read data is visible 1 clock after the sampled CAS fall.
  - COL:
    - WR fall (late write), if not already written: mem[{row,col}]<=din, dout_valid<=0, mark written.
    - At most one write per CAS access; further WR falls in the same access are ignored.
    - CAS rise: dout_valid<=0, clear the written mark, go to ROW (page mode: next CAS fall uses the same row). dout keeps its last value.
  - PRE: lasts exactly 1 cycle, then IDLE.
    - RAS fall in PRE: set err_precharge, ignore the fall.
- RAS rise in ROW or COL: go to PRE; row_open<=0, dout_valid<=0, written mark cleared. This takes priority over a simultaneous CAS rise or WR fall.
- Simultaneous RAS fall and CAS fall in IDLE:
  - The row is latched from ma and the column is also taken from ma at the same edge.
  - The access proceeds as a ROW-state CAS fall.
  - err_cas_no_ras is not set.
- WR fall while CAS is high (any state, including ROW): set err_wr_no_cas, no write.
  - Exception: a WR fall that coincides with a CAS fall counts as an early write.
- Error flags are sticky until reset and never block operation.
- No arithmetic wrap is needed: the address is a concatenation and the array is fully decoded.

Test Plan:
- Reset then read-back default:
  - Stimulus: init_n low for 2 clocks; preload mem[0x041]=0x5A via the bench backdoor; RAS fall with ma=0x01; CAS fall 2 clocks later with ma=0x01; WRn high.
  - Required: dout=0x5A and dout_valid=1 exactly 1 clock after the CAS fall is sampled; row_open=1 throughout.
- Late write then read:
  - Stimulus: RAS fall with ma=0x03; CAS fall with ma=0x07; WR fall with din=0xC3; release CAS then RAS.
  - Next cycle: RAS with ma=0x03, CAS with ma=0x07.
  - Required: the first access leaves mem[0x0C7]=0xC3; the second access gives dout=0xC3.
- Page mode:
  - Stimulus: RAS held low with ma=0x02; three CAS pulses with ma=0x00, 0x01, 0x02.
  - Required: three dout_valid pulses returning mem[0x080], mem[0x081], mem[0x082]; no PRE entry until RAS rises.
- Protocol errors:
  - Stimulus: CAS pulse with RAS high; then a WR pulse with CAS high; then RAS rise followed by a RAS fall on the very next cycle.
  - Required: err_cas_no_ras, err_wr_no_cas and err_precharge all become 1 and stay 1; the array is unchanged.
- Reset mid-access:
  - Stimulus: init_n low for 1 clock after a CAS fall but before the WR fall; hold RAS, CAS and WR low through the release.
  - Required: outputs return to 0; no write to mem[{row,col}]; after release, the still-low RAS and CAS are treated as falls. With WR low, this is an early write of din to mem[{ma,ma[COL_W-1:0]}].

Source files
------------

// File: rtl/dram_strobe_responder.sv
// DRAM-side responder for the RAS/CAS/WR strobes: latches row then column from the
// multiplexed bus, serves reads and writes from an internal array, and flags protocol misuse.
module dram_strobe_responder #(
  parameter int ROW_W  = 6,
  parameter int COL_W  = 6,
  parameter int DATA_W = 8
) (
  input  logic              xtal_in,
  input  logic              init_n,
  input  logic              t_RASn,
  input  logic              t_CASn,
  input  logic              t_RAM_WRn,
  input  logic [ROW_W-1:0]  ma,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              row_open,
  output logic              err_cas_no_ras,
  output logic              err_wr_no_cas,
  output logic              err_precharge
);
  localparam int ADDR_W = ROW_W + COL_W;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, ROW, COL, PRE} state_t;

  state_t            state;
  logic              ras_q, cas_q, wr_q;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic              written;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              ras_fall, ras_rise, cas_fall, cas_rise, wr_fall;
  logic              access_go, late_wr, mem_we;
  logic [ROW_W-1:0]  access_row;
  logic [ADDR_W-1:0] mem_addr;

  assign ras_fall = ras_q & ~t_RASn;
  assign ras_rise = ~ras_q & t_RASn;
  assign cas_fall = cas_q & ~t_CASn;
  assign cas_rise = ~cas_q & t_CASn;
  assign wr_fall  = wr_q & ~t_RAM_WRn;

  // A combined RAS+CAS fall in IDLE takes its row straight from the bus.
  always_comb begin
    access_row = (state == IDLE) ? ma : row;
    access_go  = init_n && cas_fall &&
                 (((state == ROW) && !ras_rise) || ((state == IDLE) && ras_fall));
    late_wr    = init_n && (state == COL) && !ras_rise && !cas_rise && wr_fall && !written;
    mem_addr   = late_wr ? {row, col} : {access_row, ma[COL_W-1:0]};
    mem_we     = (access_go && !t_RAM_WRn) || late_wr;
  end

  always_ff @(posedge xtal_in) begin
    if (mem_we)
      mem[mem_addr] <= din;
  end

  always_ff @(posedge xtal_in) begin
    if (!init_n) begin
      state          <= IDLE;
      ras_q          <= 1'b1;
      cas_q          <= 1'b1;
      wr_q           <= 1'b1;
      row            <= '0;
      col            <= '0;
      written        <= 1'b0;
      dout           <= '0;
      dout_valid     <= 1'b0;
      row_open       <= 1'b0;
      err_cas_no_ras <= 1'b0;
      err_wr_no_cas  <= 1'b0;
      err_precharge  <= 1'b0;
    end else begin
      ras_q <= t_RASn;
      cas_q <= t_CASn;
      wr_q  <= t_RAM_WRn;

      if (wr_fall && t_CASn)
        err_wr_no_cas <= 1'b1;

      if (access_go) begin
        col <= ma[COL_W-1:0];
        if (t_RAM_WRn) begin
          dout       <= mem[mem_addr];
          dout_valid <= 1'b1;
        end else begin
          written <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (ras_fall) begin
            row      <= ma;
            row_open <= 1'b1;
            state    <= cas_fall ? COL : ROW;
          end else if (cas_fall) begin
            err_cas_no_ras <= 1'b1;
          end
        end
        ROW: begin
          if (ras_rise) begin
            state      <= PRE;
            row_open   <= 1'b0;
            dout_valid <= 1'b0;
            written    <= 1'b0;
          end else if (cas_fall) begin
            state <= COL;
          end
        end
        COL: begin
          if (ras_rise) begin
            state      <= PRE;
            row_open   <= 1'b0;
            dout_valid <= 1'b0;
            written    <= 1'b0;
          end else if (cas_rise) begin
            state      <= ROW;
            dout_valid <= 1'b0;
            written    <= 1'b0;
          end else if (late_wr) begin
            dout_valid <= 1'b0;
            written    <= 1'b1;
          end
        end
        PRE: begin
          if (ras_fall)
            err_precharge <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_strobe_responder.sv
// Directed bench for dram_strobe_responder: a vector table for the main flows plus
// hand sequences for reset mid-access, combined RAS/CAS fall and repeated late writes.
module tb_dram_strobe_responder;
  logic       xtal_in = 1'b0;
  logic       init_n = 1'b0;
  logic       t_RASn = 1'b1, t_CASn = 1'b1, t_RAM_WRn = 1'b1;
  logic [5:0] ma = '0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       dout_valid, row_open, err_cas_no_ras, err_wr_no_cas, err_precharge;

  int checks = 0;
  int failures = 0;

  dram_strobe_responder #(.ROW_W(6), .COL_W(6), .DATA_W(8)) dut (
    .xtal_in(xtal_in), .init_n(init_n), .t_RASn(t_RASn), .t_CASn(t_CASn),
    .t_RAM_WRn(t_RAM_WRn), .ma(ma), .din(din), .dout(dout), .dout_valid(dout_valid),
    .row_open(row_open), .err_cas_no_ras(err_cas_no_ras), .err_wr_no_cas(err_wr_no_cas),
    .err_precharge(err_precharge)
  );

  always #5 xtal_in = ~xtal_in;

  typedef struct {
    logic       rst_n, ras, cas, wr;
    logic [5:0] ma;
    logic [7:0] din;
    logic [7:0] e_dout;
    logic       e_valid, e_row, e_cas, e_wr, e_pre;
  } vec_t;

  localparam int NV = 37;
  vec_t vecs [NV];

  function automatic vec_t mk(logic r, logic ra, logic ca, logic w, logic [5:0] a,
                              logic [7:0] d, logic [7:0] ed, logic ev, logic er,
                              logic ec, logic ew, logic ep);
    vec_t v;
    v.rst_n = r; v.ras = ra; v.cas = ca; v.wr = w; v.ma = a; v.din = d;
    v.e_dout = ed; v.e_valid = ev; v.e_row = er; v.e_cas = ec; v.e_wr = ew; v.e_pre = ep;
    return v;
  endfunction

  task automatic step();
    @(posedge xtal_in);
    #1;
  endtask

  task automatic drive(logic r, logic ra, logic ca, logic w, logic [5:0] a, logic [7:0] d);
    init_n = r; t_RASn = ra; t_CASn = ca; t_RAM_WRn = w; ma = a; din = d;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(string name, logic [7:0] ed, logic ev, logic er,
                          logic ec, logic ew, logic ep);
    chk(name, {19'd0, dout, dout_valid, row_open, err_cas_no_ras, err_wr_no_cas, err_precharge},
        {19'd0, ed, ev, er, ec, ew, ep});
  endtask

  initial begin
    // Backdoor preload; the array survives reset.
    dut.mem[12'h041] = 8'h5A;
    dut.mem[12'h0C7] = 8'hEE;
    dut.mem[12'h080] = 8'h11;
    dut.mem[12'h081] = 8'h22;
    dut.mem[12'h082] = 8'h33;
    dut.mem[12'h1C9] = 8'h77;
    dut.mem[12'hAAA] = 8'h00;
    dut.mem[12'h555] = 8'h6C;
    dut.mem[12'h042] = 8'h10;

    //               rst ras cas wr  ma     din    dout   v  ro ec ew ep
    vecs[0]  = mk(0, 1, 1, 1, 6'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 1, 1, 6'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 1, 1, 6'h01, 8'h00, 8'h00, 0, 1, 0, 0, 0);
    vecs[3]  = mk(1, 0, 1, 1, 6'h01, 8'h00, 8'h00, 0, 1, 0, 0, 0);
    vecs[4]  = mk(1, 0, 0, 1, 6'h01, 8'h00, 8'h5A, 1, 1, 0, 0, 0);
    vecs[5]  = mk(1, 0, 1, 1, 6'h01, 8'h00, 8'h5A, 0, 1, 0, 0, 0);
    vecs[6]  = mk(1, 1, 1, 1, 6'h01, 8'h00, 8'h5A, 0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 1, 1, 1, 6'h00, 8'h00, 8'h5A, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 0, 1, 1, 6'h03, 8'h00, 8'h5A, 0, 1, 0, 0, 0);
    vecs[9]  = mk(1, 0, 0, 1, 6'h07, 8'h00, 8'hEE, 1, 1, 0, 0, 0);
    vecs[10] = mk(1, 0, 0, 0, 6'h07, 8'hC3, 8'hEE, 0, 1, 0, 0, 0);
    vecs[11] = mk(1, 0, 1, 1, 6'h07, 8'h00, 8'hEE, 0, 1, 0, 0, 0);
    vecs[12] = mk(1, 1, 1, 1, 6'h00, 8'h00, 8'hEE, 0, 0, 0, 0, 0);
    vecs[13] = mk(1, 1, 1, 1, 6'h00, 8'h00, 8'hEE, 0, 0, 0, 0, 0);
    vecs[14] = mk(1, 0, 1, 1, 6'h03, 8'h00, 8'hEE, 0, 1, 0, 0, 0);
    vecs[15] = mk(1, 0, 0, 1, 6'h07, 8'h00, 8'hC3, 1, 1, 0, 0, 0);
    vecs[16] = mk(1, 0, 1, 1, 6'h07, 8'h00, 8'hC3, 0, 1, 0, 0, 0);
    vecs[17] = mk(1, 1, 1, 1, 6'h00, 8'h00, 8'hC3, 0, 0, 0, 0, 0);
    vecs[18] = mk(1, 1, 1, 1, 6'h00, 8'h00, 8'hC3, 0, 0, 0, 0, 0);
    vecs[19] = mk(1, 0, 1, 1, 6'h02, 8'h00, 8'hC3, 0, 1, 0, 0, 0);
    vecs[20] = mk(1, 0, 0, 1, 6'h00, 8'h00, 8'h11, 1, 1, 0, 0, 0);
    vecs[21] = mk(1, 0, 1, 1, 6'h00, 8'h00, 8'h11, 0, 1, 0, 0, 0);
    vecs[22] = mk(1, 0, 0, 1, 6'h01, 8'h00, 8'h22, 1, 1, 0, 0, 0);
    vecs[23] = mk(1, 0, 1, 1, 6'h01, 8'h00, 8'h22, 0, 1, 0, 0, 0);
    vecs[24] = mk(1, 0, 0, 1, 6'h02, 8'h00, 8'h33, 1, 1, 0, 0, 0);
    vecs[25] = mk(1, 0, 1, 1, 6'h02, 8'h00, 8'h33, 0, 1, 0, 0, 0);
    vecs[26] = mk(1, 1, 1, 1, 6'h00, 8'h00, 8'h33, 0, 0, 0, 0, 0);
    vecs[27] = mk(1, 1, 1, 1, 6'h00, 8'h00, 8'h33, 0, 0, 0, 0, 0);
    vecs[28] = mk(1, 1, 0, 1, 6'h05, 8'h00, 8'h33, 0, 0, 1, 0, 0);
    vecs[29] = mk(1, 1, 1, 1, 6'h05, 8'h00, 8'h33, 0, 0, 1, 0, 0);
    vecs[30] = mk(1, 1, 1, 0, 6'h05, 8'h9F, 8'h33, 0, 0, 1, 1, 0);
    vecs[31] = mk(1, 1, 1, 1, 6'h05, 8'h00, 8'h33, 0, 0, 1, 1, 0);
    vecs[32] = mk(1, 0, 1, 1, 6'h04, 8'h00, 8'h33, 0, 1, 1, 1, 0);
    vecs[33] = mk(1, 1, 1, 1, 6'h04, 8'h00, 8'h33, 0, 0, 1, 1, 0);
    vecs[34] = mk(1, 0, 1, 1, 6'h04, 8'h00, 8'h33, 0, 0, 1, 1, 1);
    vecs[35] = mk(1, 0, 1, 1, 6'h04, 8'h00, 8'h33, 0, 0, 1, 1, 1);
    vecs[36] = mk(1, 1, 1, 1, 6'h00, 8'h00, 8'h33, 0, 0, 1, 1, 1);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst_n, vecs[i].ras, vecs[i].cas, vecs[i].wr, vecs[i].ma, vecs[i].din);
      step();
      $display("vec %0d rst_n=%b ras=%b cas=%b wr=%b ma=%h din=%h -> dout=%h valid=%b row=%b err=%b%b%b",
               i, init_n, t_RASn, t_CASn, t_RAM_WRn, ma, din, dout, dout_valid, row_open,
               err_cas_no_ras, err_wr_no_cas, err_precharge);
      chk($sformatf("vec%0d", i),
          {19'd0, dout, dout_valid, row_open, err_cas_no_ras, err_wr_no_cas, err_precharge},
          {19'd0, vecs[i].e_dout, vecs[i].e_valid, vecs[i].e_row, vecs[i].e_cas,
           vecs[i].e_wr, vecs[i].e_pre});
    end

    chk("mem_0C7_late_write", {24'd0, dut.mem[12'h0C7]}, 32'h0000_00C3);
    chk("mem_082_after_errors", {24'd0, dut.mem[12'h082]}, 32'h0000_0033);
    chk("mem_041_after_errors", {24'd0, dut.mem[12'h041]}, 32'h0000_005A);

    // Reset in the middle of a column access, strobes still low on release.
    drive(1, 0, 1, 1, 6'h07, 8'h00); step();
    $display("seq rst_mid: ras fall row=07");
    chk_outs("rst_mid_row", 8'h33, 0, 1, 1, 1, 1);
    drive(1, 0, 0, 1, 6'h09, 8'h00); step();
    $display("seq rst_mid: cas fall col=09 dout=%h", dout);
    chk_outs("rst_mid_read", 8'h77, 1, 1, 1, 1, 1);
    drive(0, 0, 0, 0, 6'h2A, 8'h99); step();
    $display("seq rst_mid: reset with wr low dout=%h", dout);
    chk_outs("rst_mid_reset", 8'h00, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 6'h2A, 8'h99); step();
    $display("seq rst_mid: release, strobes low dout=%h row=%b", dout, row_open);
    chk_outs("rst_mid_release", 8'h00, 0, 1, 0, 0, 0);
    chk("rst_mid_no_old_write", {24'd0, dut.mem[12'h1C9]}, 32'h0000_0077);
    chk("rst_mid_early_write", {24'd0, dut.mem[12'hAAA]}, 32'h0000_0099);
    drive(1, 1, 1, 1, 6'h00, 8'h00); step();
    chk_outs("rst_mid_close", 8'h00, 0, 0, 0, 0, 0);
    step();

    // Combined RAS and CAS fall in IDLE is a read with no error.
    drive(1, 0, 0, 1, 6'h15, 8'h00); step();
    $display("seq simul: ras+cas fall ma=15 dout=%h", dout);
    chk_outs("simul_read", 8'h6C, 1, 1, 0, 0, 0);
    drive(1, 1, 1, 1, 6'h00, 8'h00); step();
    chk_outs("simul_close", 8'h6C, 0, 0, 0, 0, 0);
    step();

    // Only the first late write of a CAS access lands.
    drive(1, 0, 1, 1, 6'h01, 8'h00); step();
    drive(1, 0, 0, 1, 6'h02, 8'h00); step();
    $display("seq onewr: read 042 dout=%h", dout);
    chk_outs("onewr_read", 8'h10, 1, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 6'h02, 8'hA1); step();
    $display("seq onewr: first wr fall din=A1");
    chk_outs("onewr_first", 8'h10, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 1, 6'h02, 8'h00); step();
    drive(1, 0, 0, 0, 6'h02, 8'hB2); step();
    $display("seq onewr: second wr fall din=B2");
    chk_outs("onewr_second", 8'h10, 0, 1, 0, 0, 0);
    drive(1, 1, 1, 1, 6'h00, 8'h00); step();
    chk("onewr_mem", {24'd0, dut.mem[12'h042]}, 32'h0000_00A1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
